gate_engine: RTL and testbench
==============================

# gate_engine

Parametrised LSTM/RNN gate engine computing one gate activation vector y = act(Wx·x + Wy·h + b) in signed QN.QM fixed point. It streams one weight column per cycle from the external X and Y `weightRAM` instances and accumulates into HIDDEN_SZ parallel row MACs. It then applies saturation and a run-time selectable activation: linear, hard-sigmoid or hard-tanh. It replaces the fixed-function `gate` in the LSTM cell datapath and adds support for non-power-of-two sizes.

## Interface
- INPUT_SZ, 4: length of x; any value ≥1.
- HIDDEN_SZ, 32: length of h and y; any value ≥1.
- QN, 6: integer bits, excluding the sign bit.
- QM, 11: fractional bits.
- BITWIDTH, QN+QM+1: word width (derived).
- ADDR_X_BW, max(1,$clog2(INPUT_SZ)): X column address width (derived).
- ADDR_Y_BW, max(1,$clog2(HIDDEN_SZ)): Y column address width (derived).
- ACC_BW, 2*BITWIDTH+$clog2(INPUT_SZ+HIDDEN_SZ+1): accumulator width (derived).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- beginCalc  in  1  start request, sampled in IDLE.
- actMode  in  2  activation select: 0 linear, 1 hard-sigmoid, 2 hard-tanh, 3 treated as linear. Latched at start.
- inputVec  in  BITWIDTH  x[c] for the address issued the previous cycle.
- prevOutVec  in  BITWIDTH  h[c] for the address issued the previous cycle.
- weightMemOutput_X  in  BITWIDTH*HIDDEN_SZ  column c of Wx; row r occupies bits [r*BITWIDTH +: BITWIDTH].
- weightMemOutput_Y  in  BITWIDTH*HIDDEN_SZ  column c of Wy; same row packing.
- biasVec  in  BITWIDTH*HIDDEN_SZ  bias; must be stable from start until dataReady_gate.
- colAddressRead_X  out  ADDR_X_BW  X column read address.
- colAddressRead_Y  out  ADDR_Y_BW  Y column read address.
- busy  out  1  high from the start edge through the dataReady_gate cycle.
- dataReady_gate  out  1  one-cycle pulse: gateOutput is valid.
- gateOutput  out  BITWIDTH*HIDDEN_SZ  result vector; held until the next completion.

## Operation
- **States:**
  - IDLE → RUN_X on beginCalc.
  - RUN_X issues X addresses 0..INPUT_SZ-1, then moves to RUN_Y.
  - RUN_Y issues Y addresses 0..HIDDEN_SZ-1, then moves to DRAIN.
  - DRAIN performs the last MAC.
  - FINAL performs shift, saturation and activation.
  - DONE → IDLE.
- **Read latency:** 1 cycle. The address issued in cycle k has its column and scalar valid in cycle k+1.
- **Start edge:** each accumulator acc[r] loads sign-extended b[r] << QM, and actMode is latched.
- **MAC:** acc[r] += W[r][c]·v[c], full-precision signed product (2·BITWIDTH bits, 2·QM fractional bits). No intermediate overflow is possible at ACC_BW.
- **Scaling:** z = acc >>> QM (arithmetic shift, floor rounding). s = z saturated to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1].
- **Linear:** y = s.
- **Hard-sigmoid:** y = clamp((s >>> 2) + 2^(QM−1), 0, 2^QM).
- **Hard-tanh:** y = clamp(s, −2^QM, 2^QM).
- **beginCalc while busy:** ignored, with no queuing.
- **beginCalc in the DONE cycle:** ignored. A start is accepted only when the state is IDLE.
- **Address outputs:** both read addresses are 0 outside their own RUN phase.
- **Reset** (including mid-run):
  - State → IDLE; busy = 0, dataReady_gate = 0.
  - Both addresses = 0; gateOutput = 0; accumulators cleared.
  - Any partial result is discarded.

## Timing
- Let t0 be the edge that samples beginCalc=1 in IDLE, and N = INPUT_SZ + HIDDEN_SZ.
- **Address sequence:**
  - colAddressRead_X = c during cycle (t0+c, t0+c+1), for c < INPUT_SZ.
  - colAddressRead_Y = c during cycle (t0+INPUT_SZ+c, …), for c < HIDDEN_SZ.
- **MAC timing:** the MAC for issue cycle k occurs at edge t0+k+2. The last MAC is at edge t0+N+1.
- **Completion:** gateOutput updates and dataReady_gate rises at edge t0+N+2, and stays high for exactly one cycle. busy falls at edge t0+N+3.
- **Throughput:** the earliest next start is edge t0+N+3, so one result every N+3 cycles.
- **Reset values:** every output is 0.

## Test plan
Bench configuration: QN=6, QM=11, INPUT_SZ=4, HIDDEN_SZ=32, so 1.0 = 2048.

1. **Linear sum:** Wx=1.0, x=1.0, Wy=0, h=0, b=0, mode 0 → every row 8192 (4.0). dataReady_gate pulses exactly once, at edge t0+38. Address sequences are checked against the Timing section.
2. **Saturation:** Wx=31.0, x=31.0, mode 0 → every row 131071 (0x1FFFF). With Wx=−31.0 → every row 0x20000 (−131072).
3. **Floor rounding and bias:**
   - Wx[0][0] = −1 LSB (0x3FFFF), x[0] = 1 LSB, all else 0 → row 0 = 0x3FFFF (−1 LSB).
   - With b[5] = 3.5 additionally set → row 5 = 7168.
4. **Activations, W=0:**
   - Hard-sigmoid with b = 0 / 4.0 / −4.0 → 1024 / 2048 / 0.
   - Hard-tanh with b = 0.5 / 3.0 / −3.0 → 1024 / 2048 / −2048 (0x3F800).
5. **Control:**
   - beginCalc re-asserted at t0+5 and held through DONE → exactly one dataReady_gate pulse.
   - reset at t0+10 → next cycle all outputs 0 and state IDLE. A fresh start then reproduces scenario 1 exactly.
6. **Non-power-of-two sizes:** INPUT_SZ=3, HIDDEN_SZ=5, Wx=Wy=1.0, x=h=0.5, b=0 → every row 8192 (4.0). The X address never exceeds 2, and dataReady_gate rises at edge t0+10.

Source files
------------

// File: rtl/gate_engine.sv
// LSTM/RNN gate engine: y = act(Wx*x + Wy*h + b) in signed QN.QM fixed point,
// one weight column per cycle into HIDDEN_SZ parallel row accumulators.
//
// state | meaning
// IDLE  | waiting for beginCalc
// RUN_X | issuing X column addresses 0..INPUT_SZ-1
// RUN_Y | issuing Y column addresses 0..HIDDEN_SZ-1
// DRAIN | last MAC lands (one-cycle read latency)
// FINAL | shift, saturate and activate into gateOutput
// DONE  | dataReady_gate pulse
module gate_engine #(
  parameter int INPUT_SZ  = 4,
  parameter int HIDDEN_SZ = 32,
  parameter int QN        = 6,
  parameter int QM        = 11,
  parameter int BITWIDTH  = QN + QM + 1,
  parameter int ADDR_X_BW = (INPUT_SZ > 1) ? $clog2(INPUT_SZ) : 1,
  parameter int ADDR_Y_BW = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1,
  parameter int ACC_BW    = 2 * BITWIDTH + $clog2(INPUT_SZ + HIDDEN_SZ + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          beginCalc,
  input  logic [1:0]                    actMode,
  input  logic [BITWIDTH-1:0]           inputVec,
  input  logic [BITWIDTH-1:0]           prevOutVec,
  input  logic [BITWIDTH*HIDDEN_SZ-1:0] weightMemOutput_X,
  input  logic [BITWIDTH*HIDDEN_SZ-1:0] weightMemOutput_Y,
  input  logic [BITWIDTH*HIDDEN_SZ-1:0] biasVec,
  output logic [ADDR_X_BW-1:0]          colAddressRead_X,
  output logic [ADDR_Y_BW-1:0]          colAddressRead_Y,
  output logic                          busy,
  output logic                          dataReady_gate,
  output logic [BITWIDTH*HIDDEN_SZ-1:0] gateOutput
);

  localparam int CNT_BW = (ADDR_X_BW > ADDR_Y_BW) ? ADDR_X_BW : ADDR_Y_BW;
  localparam logic [CNT_BW-1:0] LAST_X = CNT_BW'(INPUT_SZ - 1);
  localparam logic [CNT_BW-1:0] LAST_Y = CNT_BW'(HIDDEN_SZ - 1);

  localparam logic signed [ACC_BW-1:0] SAT_MAX =
    {{(ACC_BW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] SAT_MIN =
    {{(ACC_BW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
  localparam logic signed [BITWIDTH+1:0] ONE     = (BITWIDTH+2)'(1) <<< QM;
  localparam logic signed [BITWIDTH+1:0] HALF    = ONE >>> 1;
  localparam logic signed [BITWIDTH+1:0] NEG_ONE = -ONE;

  typedef enum logic [2:0] {IDLE, RUN_X, RUN_Y, DRAIN, FINAL, DONE} state_t;

  state_t                      state, state_nxt;
  logic [CNT_BW-1:0]           cnt;
  logic                        last_x, last_y;
  logic                        mac_en, mac_y;
  logic [1:0]                  mode;
  logic signed [ACC_BW-1:0]    acc [HIDDEN_SZ];
  logic [BITWIDTH*HIDDEN_SZ-1:0] result;

  function automatic logic signed [ACC_BW-1:0] mac_term(
    input logic [BITWIDTH-1:0] w,
    input logic [BITWIDTH-1:0] v
  );
    logic signed [2*BITWIDTH-1:0] p;
    p = $signed(w) * $signed(v);
    return ACC_BW'(p);
  endfunction

  function automatic logic signed [ACC_BW-1:0] bias_term(input logic [BITWIDTH-1:0] b);
    logic signed [ACC_BW-1:0] t;
    t = ACC_BW'($signed(b));
    return t <<< QM;
  endfunction

  // Floor-shift, saturate to the word range, then apply the latched activation.
  function automatic logic [BITWIDTH-1:0] activate(
    input logic signed [ACC_BW-1:0] a,
    input logic [1:0]               m
  );
    logic signed [ACC_BW-1:0]     z;
    logic signed [BITWIDTH-1:0]   s;
    logic signed [BITWIDTH+1:0]   sx;
    logic signed [BITWIDTH+1:0]   hs;
    logic [BITWIDTH-1:0]          y;
    z = a >>> QM;
    if (z > SAT_MAX)      s = SAT_MAX[BITWIDTH-1:0];
    else if (z < SAT_MIN) s = SAT_MIN[BITWIDTH-1:0];
    else                  s = z[BITWIDTH-1:0];
    sx = (BITWIDTH+2)'(s);
    hs = (sx >>> 2) + HALF;
    case (m)
      2'd1: begin
        if (hs < 0)        y = '0;
        else if (hs > ONE) y = ONE[BITWIDTH-1:0];
        else               y = hs[BITWIDTH-1:0];
      end
      2'd2: begin
        if (sx > ONE)          y = ONE[BITWIDTH-1:0];
        else if (sx < NEG_ONE) y = NEG_ONE[BITWIDTH-1:0];
        else                   y = s;
      end
      default: y = s;
    endcase
    return y;
  endfunction

  assign last_x = (cnt == LAST_X);
  assign last_y = (cnt == LAST_Y);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beginCalc) state_nxt = RUN_X;
      RUN_X:   if (last_x)    state_nxt = RUN_Y;
      RUN_Y:   if (last_y)    state_nxt = DRAIN;
      DRAIN:   state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    for (int r = 0; r < HIDDEN_SZ; r++)
      result[r*BITWIDTH +: BITWIDTH] = activate(acc[r], mode);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mac_en     <= 1'b0;
      mac_y      <= 1'b0;
      mode       <= 2'd0;
      gateOutput <= '0;
      for (int r = 0; r < HIDDEN_SZ; r++) acc[r] <= '0;
    end else begin
      state  <= state_nxt;
      // MAC runs one cycle behind the issued address to match the RAM latency.
      mac_en <= (state == RUN_X) || (state == RUN_Y);
      mac_y  <= (state == RUN_Y);
      if ((state == RUN_X && !last_x) || (state == RUN_Y && !last_y))
        cnt <= cnt + CNT_BW'(1);
      else
        cnt <= '0;
      if (state == IDLE && beginCalc) begin
        mode <= actMode;
        for (int r = 0; r < HIDDEN_SZ; r++)
          acc[r] <= bias_term(biasVec[r*BITWIDTH +: BITWIDTH]);
      end else if (mac_en) begin
        for (int r = 0; r < HIDDEN_SZ; r++)
          acc[r] <= acc[r] + mac_term(
            mac_y ? weightMemOutput_Y[r*BITWIDTH +: BITWIDTH]
                  : weightMemOutput_X[r*BITWIDTH +: BITWIDTH],
            mac_y ? prevOutVec : inputVec);
      end
      if (state == FINAL) gateOutput <= result;
    end
  end

  assign colAddressRead_X = (state == RUN_X) ? cnt[ADDR_X_BW-1:0] : '0;
  assign colAddressRead_Y = (state == RUN_Y) ? cnt[ADDR_Y_BW-1:0] : '0;
  assign busy             = (state != IDLE);
  assign dataReady_gate   = (state == DONE);

endmodule

// File: tb/tb_gate_engine.sv
// Directed bench for gate_engine: RAM model with one-cycle latency, scoreboard
// of expected result vectors, per-cycle address/handshake checks.
module tb_gate_engine;
  localparam int IN = 4, HID = 32, BW = 18, GW = BW * HID, N = IN + HID;
  localparam int IN2 = 3, HID2 = 5, N2 = IN2 + HID2;

  logic clock = 1'b0, reset = 1'b1, beginCalc = 1'b0, beginCalc2 = 1'b0;
  logic [1:0] actMode = 2'd0;
  logic [BW-1:0] inputVec, prevOutVec;
  logic [GW-1:0] wX, wY, biasVec;
  logic [1:0] addrX;
  logic [4:0] addrY;
  logic busy, rdy;
  logic [GW-1:0] gout;

  logic [1:0] addrX2;
  logic [2:0] addrY2;
  logic busy2, rdy2;
  logic [BW*HID2-1:0] gout2;

  logic [BW-1:0] xm [IN];
  logic [BW-1:0] hm [HID];
  logic [GW-1:0] wxm [IN];
  logic [GW-1:0] wym [HID];
  logic [GW-1:0] exp_q [$];

  int errors = 0, checks = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    inputVec   <= xm[addrX];
    prevOutVec <= hm[addrY];
    wX         <= wxm[addrX];
    wY         <= wym[addrY];
  end

  gate_engine #(.INPUT_SZ(IN), .HIDDEN_SZ(HID), .QN(6), .QM(11)) dut (
    .clock(clock), .reset(reset), .beginCalc(beginCalc), .actMode(actMode),
    .inputVec(inputVec), .prevOutVec(prevOutVec),
    .weightMemOutput_X(wX), .weightMemOutput_Y(wY), .biasVec(biasVec),
    .colAddressRead_X(addrX), .colAddressRead_Y(addrY),
    .busy(busy), .dataReady_gate(rdy), .gateOutput(gout));

  gate_engine #(.INPUT_SZ(IN2), .HIDDEN_SZ(HID2), .QN(6), .QM(11)) dut2 (
    .clock(clock), .reset(reset), .beginCalc(beginCalc2), .actMode(2'd0),
    .inputVec(18'd1024), .prevOutVec(18'd1024),
    .weightMemOutput_X({HID2{18'd2048}}), .weightMemOutput_Y({HID2{18'd2048}}),
    .biasVec({(BW*HID2){1'b0}}),
    .colAddressRead_X(addrX2), .colAddressRead_Y(addrY2),
    .busy(busy2), .dataReady_gate(rdy2), .gateOutput(gout2));

  task automatic check(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [GW-1:0] rep(input logic [BW-1:0] v);
    logic [GW-1:0] t;
    for (int r = 0; r < HID; r++) t[r*BW +: BW] = v;
    return t;
  endfunction

  task automatic set_mem(input logic [BW-1:0] wxv, input logic [BW-1:0] xv,
                         input logic [BW-1:0] wyv, input logic [BW-1:0] hv);
    for (int c = 0; c < IN; c++) begin wxm[c] = rep(wxv); xm[c] = xv; end
    for (int c = 0; c < HID; c++) begin wym[c] = rep(wyv); hm[c] = hv; end
  endtask

  // One computation; hold_from re-asserts beginCalc from that edge through DONE,
  // rst_at applies reset at that edge and abandons the run.
  task automatic run(input logic [1:0] mode, input logic [GW-1:0] expv, input string tag,
                     input int hold_from, input int rst_at);
    int pulses;
    int ex, ey;
    logic [8:0] ec;
    logic [GW-1:0] e;
    pulses = 0;
    @(negedge clock);
    actMode = mode;
    beginCalc = 1'b1;
    @(posedge clock);
    exp_q.push_back(expv);
    for (int k = 0; k <= N + 5; k++) begin
      @(negedge clock);
      if (rst_at >= 0 && k == rst_at) begin
        check({tag, "_rst_ctrl"}, GW'({addrX, addrY, busy, rdy}), '0);
        check({tag, "_rst_out"}, gout, '0);
        reset = 1'b0;
        e = exp_q.pop_back();
        return;
      end
      actMode = mode ^ 2'b01;
      beginCalc = (hold_from >= 0 && k + 1 >= hold_from && k + 1 <= N + 3);
      if (rst_at >= 0 && k + 1 == rst_at) reset = 1'b1;
      ex = (k < IN) ? k : 0;
      ey = (k >= IN && k < N) ? k - IN : 0;
      ec = {2'(ex), 5'(ey), (k <= N + 2), (k == N + 2)};
      check($sformatf("%s_ctrl_c%0d", tag, k), GW'({addrX, addrY, busy, rdy}), GW'(ec));
      if (rdy) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s_sb observed=no entry expected=entry", tag);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_out"}, gout, e);
        end
      end
    end
    check({tag, "_pulses"}, GW'(pulses), GW'(1));
    beginCalc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [GW-1:0] e;
    int pulses2;
    logic [6:0] ec2;
    set_mem('0, '0, '0, '0);
    biasVec = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ctrl", GW'({addrX, addrY, busy, rdy}), '0);
    check("reset_out", gout, '0);
    check("reset2", GW'({addrX2, addrY2, busy2, rdy2, gout2}), '0);
    reset = 1'b0;

    set_mem(18'd2048, 18'd2048, '0, '0);
    run(2'd0, rep(18'd8192), "linear", -1, -1);

    // x ramp through X, diagonal Wy with h[c]=c*64: row r = 5120 + 64*r
    for (int c = 0; c < IN; c++) begin wxm[c] = rep(18'd2048); xm[c] = 18'(512 * (c + 1)); end
    for (int c = 0; c < HID; c++) begin
      wym[c] = '0;
      wym[c][c*BW +: BW] = 18'd2048;
      hm[c] = 18'(64 * c);
    end
    for (int r = 0; r < HID; r++) e[r*BW +: BW] = 18'(5120 + 64 * r);
    run(2'd0, e, "ramp", -1, -1);

    set_mem(18'd63488, 18'd63488, '0, '0);
    run(2'd0, rep(18'h1FFFF), "sat_pos", -1, -1);
    set_mem(18'h30800, 18'd63488, '0, '0);
    run(2'd0, rep(18'h20000), "sat_neg", -1, -1);

    set_mem('0, '0, '0, '0);
    wxm[0][0 +: BW] = 18'h3FFFF;
    xm[0] = 18'd1;
    biasVec[5*BW +: BW] = 18'd7168;
    e = '0;
    e[0 +: BW] = 18'h3FFFF;
    e[5*BW +: BW] = 18'd7168;
    run(2'd0, e, "floor_bias", -1, -1);

    set_mem('0, '0, '0, '0);
    biasVec = rep(18'd0);     run(2'd1, rep(18'd1024), "hsig_0", -1, -1);
    biasVec = rep(18'd8192);  run(2'd1, rep(18'd2048), "hsig_p4", -1, -1);
    biasVec = rep(18'h3E000); run(2'd1, rep(18'd0), "hsig_m4", -1, -1);
    biasVec = rep(18'h3FFFF); run(2'd1, rep(18'd1023), "hsig_m1lsb", -1, -1);
    biasVec = rep(18'd1024);  run(2'd2, rep(18'd1024), "htanh_half", -1, -1);
    biasVec = rep(18'd6144);  run(2'd2, rep(18'd2048), "htanh_p3", -1, -1);
    biasVec = rep(18'h3E800); run(2'd2, rep(18'h3F800), "htanh_m3", -1, -1);
    biasVec = rep(18'd6144);  run(2'd3, rep(18'd6144), "mode3_lin", -1, -1);

    biasVec = '0;
    set_mem(18'd2048, 18'd2048, '0, '0);
    run(2'd0, rep(18'd8192), "hold", 5, -1);
    run(2'd0, rep(18'd8192), "midreset", -1, 10);
    run(2'd0, rep(18'd8192), "after_reset", -1, -1);

    pulses2 = 0;
    @(negedge clock);
    beginCalc2 = 1'b1;
    @(posedge clock);
    for (int k = 0; k <= N2 + 4; k++) begin
      @(negedge clock);
      beginCalc2 = 1'b0;
      ec2 = {2'((k < IN2) ? k : 0), 3'((k >= IN2 && k < N2) ? k - IN2 : 0),
             (k <= N2 + 2), (k == N2 + 2)};
      check($sformatf("np2_ctrl_c%0d", k), GW'({addrX2, addrY2, busy2, rdy2}), GW'(ec2));
      if (rdy2) begin
        pulses2++;
        check("np2_out", GW'(gout2), GW'({HID2{18'd8192}}));
      end
    end
    check("np2_pulses", GW'(pulses2), GW'(1));
    check("sb_empty", GW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
